// File: rtl/es1_device_pkg.sv
// Device-name and reset-bit helpers shared by the ES1 register banks.
// is_xilinx picks the primitive build; bit_is_resettable spots 0/1 reset bits.
package es1_device_pkg;

   function automatic bit is_xilinx(string dev);
      return dev == "SPARTAN6"
          || dev == "VIRTEX6"
          || dev == "7SERIES"
          || dev == "ULTRASCALE"
          || dev == "ULTRASCALE_PLUS"
          || dev == "ULTRASCALE_PLUS_ES1"
          || dev == "ULTRASCALE_PLUS_ES2";
   endfunction

   // x/z reset bits mean "this flop has no reset"
   function automatic bit bit_is_resettable(logic b);
      return (b === 1'b0) || (b === 1'b1);
   endfunction

endpackage

// File: rtl/es1_xilinx_ff_bit.sv
// One register bit: FDRE/FDSE on Xilinx unisim flows, behavioural otherwise.
// Ports: clk, reset (sync, high), cke (load), d_i (data), q_o (registered).
module es1_xilinx_ff_bit
   import es1_device_pkg::*;
#(
   parameter logic  INIT_BIT   = 1'bx,
   parameter string DEVICE     = "RTL",
   parameter string SIMULATION = "false",
   parameter string DEBUG      = "false"
) (
   input  logic clk,
   input  logic reset,
   input  logic cke,
   input  logic d_i,
   output logic q_o
);

   localparam bit   RST_EN = bit_is_resettable(INIT_BIT);
   localparam logic INIT_V = RST_EN ? INIT_BIT : 1'b0;

   // unisim cells only exist where the Xilinx library is compiled in
`ifdef ES1_XILINX_UNISIM
   localparam bit HAVE_UNISIM = 1'b1;
`else
   localparam bit HAVE_UNISIM = 1'b0;
`endif

   localparam bit PRIM = HAVE_UNISIM
                      && is_xilinx(DEVICE)
                      && (SIMULATION != "true");

   logic q;

   if (PRIM) begin : g_prim
`ifdef ES1_XILINX_UNISIM
      if (RST_EN && INIT_V) begin : g_fdse
         FDSE #(.INIT(1'b1)) u_fdse (
            .Q  (q),
            .C  (clk),
            .CE (cke),
            .S  (reset),
            .D  (d_i)
         );
      end else begin : g_fdre
         FDRE #(.INIT(1'b0)) u_fdre (
            .Q  (q),
            .C  (clk),
            .CE (cke),
            .R  (RST_EN ? reset : 1'b0),
            .D  (d_i)
         );
      end
`endif
   end else begin : g_beh
      // power-up value matches the primitive INIT
      logic q_q = INIT_V;
      always_ff @(posedge clk) begin
         if (RST_EN && reset)
            q_q <= INIT_V;
         else if (cke)
            q_q <= d_i;
      end
      assign q = q_q;
   end

   if (DEBUG == "true") begin : g_dbg
      (* mark_debug = "true" *) logic q_dbg;
      assign q_dbg = q;
      assign q_o   = q_dbg;
   end else begin : g_nodbg
      assign q_o = q;
   end

endmodule

// File: rtl/es1_xilinx_flipflops.sv
// Final-stage register bank: clock enable plus per-bit sync reset-to-constant.
// Ports: clk, reset (sync, high), cke (load), din/dout (data_t); BYPASS = wire.
module es1_xilinx_flipflops
   import es1_device_pkg::*;
#(
   parameter bit    BYPASS      = 1'b0,
   parameter int    DATA_BITS   = 8,
   parameter type   data_t      = logic [DATA_BITS-1:0],
   parameter data_t RESET_VALUE = 'x,
   parameter string DEVICE      = "RTL",
   parameter string SIMULATION  = "false",
   parameter string DEBUG       = "false"
) (
   input  logic  clk,
   input  logic  reset,
   input  logic  cke,
   input  data_t din,
   output data_t dout
);

   localparam int          W  = $bits(data_t);
   localparam logic [W-1:0] RV = RESET_VALUE;

   if (BYPASS) begin : g_byp
      logic unused_ok;
      assign unused_ok = ^{clk, reset, cke};
      assign dout      = din;
   end else begin : g_reg
      logic [W-1:0] d_flat;
      logic [W-1:0] q_flat;

      assign d_flat = din;

      for (genvar b = 0; b < W; b++) begin : g_bit
         es1_xilinx_ff_bit #(
            .INIT_BIT   (RV[b]),
            .DEVICE     (DEVICE),
            .SIMULATION (SIMULATION),
            .DEBUG      (DEBUG)
         ) u_bit (
            .clk   (clk),
            .reset (reset),
            .cke   (cke),
            .d_i   (d_flat[b]),
            .q_o   (q_flat[b])
         );
      end

      assign dout = data_t'(q_flat);
   end

endmodule

// File: tb/tb_es1_xilinx_flipflops.sv
// Bench for es1_xilinx_flipflops: RTL, primitive-device, partial-reset and
// bypass builds checked against a per-bit reference model.
module tb_es1_xilinx_flipflops;

   logic       clk = 1'b0;
   logic       reset;
   logic       cke;
   logic [7:0] din;
   logic [7:0] dout_rtl;
   logic [7:0] dout_us;
   logic [7:0] dout_part;
   logic [7:0] dout_byp;

   int vecs = 0;
   int errs = 0;

   // reference state; mask marks resettable bits
   localparam logic [7:0] RV_FULL   = 8'hA5;
   localparam logic [7:0] MSK_FULL  = 8'hFF;
   localparam logic [7:0] RV_PART   = 8'h05;
   localparam logic [7:0] MSK_PART  = 8'h0F;
   logic [7:0] m_full;
   logic [7:0] m_part;

   always #5 clk = ~clk;

   es1_xilinx_flipflops #(
      .BYPASS(1'b0), .DATA_BITS(8), .RESET_VALUE(8'hA5),
      .DEVICE("RTL"), .SIMULATION("false"), .DEBUG("false")
   ) dut_rtl (
      .clk(clk), .reset(reset), .cke(cke), .din(din), .dout(dout_rtl)
   );

   es1_xilinx_flipflops #(
      .BYPASS(1'b0), .DATA_BITS(8), .RESET_VALUE(8'hA5),
      .DEVICE("ULTRASCALE_PLUS"), .SIMULATION("true"), .DEBUG("true")
   ) dut_us (
      .clk(clk), .reset(reset), .cke(cke), .din(din), .dout(dout_us)
   );

   es1_xilinx_flipflops #(
      .BYPASS(1'b0), .DATA_BITS(8), .RESET_VALUE(8'bxxxx_0101),
      .DEVICE("RTL"), .SIMULATION("false"), .DEBUG("false")
   ) dut_part (
      .clk(clk), .reset(reset), .cke(cke), .din(din), .dout(dout_part)
   );

   es1_xilinx_flipflops #(
      .BYPASS(1'b1), .DATA_BITS(8), .RESET_VALUE(8'hA5),
      .DEVICE("RTL"), .SIMULATION("false"), .DEBUG("false")
   ) dut_byp (
      .clk(clk), .reset(reset), .cke(cke), .din(din), .dout(dout_byp)
   );

   // clear beats load beats hold, bit by bit
   function automatic logic [7:0] next_val(logic [7:0] cur,
                                           logic [7:0] rv,
                                           logic [7:0] msk,
                                           logic r, logic ce,
                                           logic [7:0] d);
      logic [7:0] keep_or_load;
      logic [7:0] rmask;
      keep_or_load = ce ? d : cur;
      rmask        = r ? msk : 8'h00;
      return (rv & rmask) | (keep_or_load & ~rmask);
   endfunction

   task automatic tick();
      @(posedge clk);
      m_full = next_val(m_full, RV_FULL, MSK_FULL, reset, cke, din);
      m_part = next_val(m_part, RV_PART, MSK_PART, reset, cke, din);
      #1;
   endtask

   task automatic test_reset();
      #1;
      vecs++;
      if (dout_rtl !== 8'hA5) begin
         $display("FAIL powerup_rtl got %h want %h", dout_rtl, 8'hA5);
         errs++;
      end
      vecs++;
      if (dout_us !== 8'hA5) begin
         $display("FAIL powerup_us got %h want %h", dout_us, 8'hA5);
         errs++;
      end
      vecs++;
      if (dout_part !== 8'h05) begin
         $display("FAIL powerup_part got %h want %h", dout_part, 8'h05);
         errs++;
      end
   endtask

   task automatic test_load();
      reset = 1'b0; cke = 1'b1; din = 8'h3C;
      tick();
      vecs++;
      if (dout_rtl !== 8'h3C) begin
         $display("FAIL load_rtl got %h want %h", dout_rtl, 8'h3C);
         errs++;
      end
      vecs++;
      if (dout_us !== 8'h3C) begin
         $display("FAIL load_us got %h want %h", dout_us, 8'h3C);
         errs++;
      end
   endtask

   task automatic test_hold();
      cke = 1'b0;
      for (int i = 0; i < 4; i++) begin
         din = (i % 2 == 0) ? 8'hFF : 8'h00;
         tick();
         vecs++;
         if (dout_rtl !== 8'h3C || dout_us !== 8'h3C) begin
            $display("FAIL hold%0d got %h/%h want %h",
                     i, dout_rtl, dout_us, 8'h3C);
            errs++;
         end
      end
   endtask

   task automatic test_reset_priority();
      reset = 1'b1; cke = 1'b1; din = 8'h0F;
      tick();
      vecs++;
      if (dout_rtl !== 8'hA5 || dout_us !== 8'hA5) begin
         $display("FAIL rst_prio got %h/%h want %h",
                  dout_rtl, dout_us, 8'hA5);
         errs++;
      end
      vecs++;
      if (dout_part !== m_part) begin
         $display("FAIL rst_prio_part got %h want %h", dout_part, m_part);
         errs++;
      end
      reset = 1'b0;
      tick();
      vecs++;
      if (dout_rtl !== 8'h0F || dout_us !== 8'h0F) begin
         $display("FAIL rst_release got %h/%h want %h",
                  dout_rtl, dout_us, 8'h0F);
         errs++;
      end
   endtask

   task automatic test_reset_no_cke();
      reset = 1'b1; cke = 1'b0; din = 8'h77;
      tick();
      vecs++;
      if (dout_rtl !== 8'hA5 || dout_us !== 8'hA5) begin
         $display("FAIL rst_nocke got %h/%h want %h",
                  dout_rtl, dout_us, 8'hA5);
         errs++;
      end
   endtask

   task automatic test_partial();
      reset = 1'b0; cke = 1'b1; din = 8'hF0;
      tick();
      vecs++;
      if (dout_part !== 8'hF0) begin
         $display("FAIL part_load got %h want %h", dout_part, 8'hF0);
         errs++;
      end
      reset = 1'b1; cke = 1'b0; din = 8'h00;
      tick();
      vecs++;
      if (dout_part !== 8'hF5) begin
         $display("FAIL part_reset got %h want %h", dout_part, 8'hF5);
         errs++;
      end
      vecs++;
      if (dout_rtl !== 8'hA5) begin
         $display("FAIL part_full got %h want %h", dout_rtl, 8'hA5);
         errs++;
      end
   endtask

   task automatic test_bypass();
      @(negedge clk);
      din = 8'h5A; reset = 1'b1; cke = 1'b0;
      #1;
      vecs++;
      if (dout_byp !== 8'h5A) begin
         $display("FAIL bypass got %h want %h", dout_byp, 8'h5A);
         errs++;
      end
      din = 8'hC3; reset = 1'b0; cke = 1'b1;
      #1;
      vecs++;
      if (dout_byp !== 8'hC3) begin
         $display("FAIL bypass2 got %h want %h", dout_byp, 8'hC3);
         errs++;
      end
      // realign the model with the edge that follows
      reset = 1'b0; cke = 1'b0;
      tick();
   endtask

   task automatic test_random();
      for (int i = 0; i < 300; i++) begin
         reset = ($urandom_range(0, 7) == 0);
         cke   = $urandom_range(0, 1);
         din   = 8'($urandom);
         tick();
         vecs++;
         if (dout_rtl !== m_full) begin
            $display("FAIL rnd_rtl%0d got %h want %h", i, dout_rtl, m_full);
            errs++;
         end
         vecs++;
         if (dout_us !== m_full) begin
            $display("FAIL rnd_us%0d got %h want %h", i, dout_us, m_full);
            errs++;
         end
         vecs++;
         if (dout_part !== m_part) begin
            $display("FAIL rnd_part%0d got %h want %h", i, dout_part, m_part);
            errs++;
         end
         vecs++;
         if (dout_byp !== din) begin
            $display("FAIL rnd_byp%0d got %h want %h", i, dout_byp, din);
            errs++;
         end
      end
   endtask

   initial begin
      reset  = 1'b0;
      cke    = 1'b0;
      din    = 8'h00;
      m_full = RV_FULL;
      m_part = RV_PART;
      test_reset();
      test_load();
      test_hold();
      test_reset_priority();
      test_reset_no_cke();
      test_partial();
      test_bypass();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end

endmodule

// File: doc/es1_xilinx_flipflops.md
# es1_xilinx_flipflops

Parameterizable register bank for the final pipeline stage of the ES1 SPU operator blocks. It registers a bus of arbitrary type with a clock enable and a synchronous, per-bit reset-to-constant. On Xilinx devices it is built from explicit FDRE/FDSE primitives, one per bit; otherwise it is behavioural RTL. An optional bypass turns it into a wire.

## Interface

Parameters:
- BYPASS, 1'b0: 1 makes dout a combinational copy of din; reset, cke and clk are ignored.
- DATA_BITS, 8: payload width.
- data_t, logic [DATA_BITS-1:0]: payload type. Width used internally is $bits(data_t).
- RESET_VALUE, 'x (data_t): per-bit reset and power-up value. 0/1 bits are reset to that value; x/z bits are "no reset".
- DEVICE, "RTL": one of "SPARTAN6", "VIRTEX6", "7SERIES", "ULTRASCALE", "ULTRASCALE_PLUS", "ULTRASCALE_PLUS_ES1", "ULTRASCALE_PLUS_ES2" (primitive build) or anything else (behavioural build).
- SIMULATION, "false": "true" makes the primitive build use the behavioural model instead of unisim cells.
- DEBUG, "false": "true" puts a mark_debug="true" attribute on the register outputs.

Ports:
- clk, in, 1: clock, rising edge.
- reset, in, 1: synchronous, active-high; clock clk.
- cke, in, 1: clock enable (load).
- din, in, data_t: data in.
- dout, out, data_t: registered data out.

## Operation

- BYPASS=1: dout = din with no storage. No primitives are instantiated.
- BYPASS=0, evaluated per bit b at each rising clk edge:
  - reset=1 and RESET_VALUE[b] is 0/1: dout[b] takes RESET_VALUE[b]. This happens regardless of cke; reset has priority over cke (FDRE/FDSE semantics).
  - Otherwise, if cke=1: dout[b] takes din[b].
  - Otherwise: dout[b] holds.
  - If RESET_VALUE[b] is x/z: reset is ignored for that bit (R/S input tied 0).
- Primitive mapping:
  - RESET_VALUE[b]=1 uses FDSE with INIT=1.
  - RESET_VALUE[b]=0 uses FDRE with INIT=0.
  - RESET_VALUE[b]=x/z uses FDRE with INIT=0 and R=0.
- Power-up value: RESET_VALUE, with x/z bits read as 0. The behavioural build uses an initial value to match.
- The behavioural and primitive builds are cycle- and bit-identical for 0/1 inputs.

## Timing

- Latency is 1 clk from din/cke to dout when BYPASS=0, and 0 when BYPASS=1.
- Reset takes effect at the same edge it is sampled, with no recovery cycle. The next edge with reset=0 and cke=1 loads din.
- reset and cke both high on the same edge: the reset value wins for resettable bits; non-resettable bits load din.
- Callers drive reset=cke&&clear and cke=cke&&valid. The outcome is clear over valid over hold.

## Structure

- Shared package es1_device_pkg holds:
  - function is_xilinx(string) returning 1 for the seven DEVICE names above;
  - function bit_is_resettable(logic) returning 1 for 0/1.
- One sub-module, es1_xilinx_ff_bit, implements one bit. It has parameters INIT_BIT (logic), DEVICE, SIMULATION and DEBUG, and selects FDRE, FDSE or the behavioural flop.
- The top level is a generate loop over $bits(data_t), casting din/dout to and from a flat logic vector, plus the bypass branch.

## Test plan

- Basic load, BYPASS=0, DATA_BITS=8, RESET_VALUE=8'hA5: after power-up dout=8'hA5. Then cke=1, din=8'h3C gives dout=8'h3C after 1 clk.
- Hold: cke=0 while din toggles 8'hFF/8'h00 for 4 clk leaves dout=8'h3C throughout.
- Reset priority: reset=1, cke=1, din=8'h0F gives dout=8'hA5 on that edge. Next edge with reset=0, cke=1 gives dout=8'h0F.
- Reset without cke: reset=1, cke=0 gives dout=8'hA5 (reset is independent of cke).
- Partial reset, RESET_VALUE=8'bxxxx_0101, previous dout=8'hF0: reset=1, cke=0 gives dout=8'hF5, so the upper nibble holds.
- Bypass, BYPASS=1: din=8'h5A gives dout=8'h5A in the same cycle, with reset/cke ignored. Repeat the first five scenarios with DEVICE="RTL" and DEVICE="ULTRASCALE_PLUS" and compare the two builds bit-for-bit.
